// File: rtl/icache_miss_handler.sv
// ---------------------------------------------------------------------------
// icache_miss_handler
//
// Purpose:
//   Miss/fill controller that sits between instruction fetch and a 4-set,
//   64-byte-line icache array with 24-bit physical tags. A lookup hits when
//   the array reports a valid line whose tag equals the TLB tag. On a miss,
//   fetch is stalled in the same cycle. The line is then requested from
//   memory, and its 16 beats are written into the array one beat at a time.
//   Finally the lookup is replayed.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   fe_req          fetch lookup valid
//   fe_va           fetch virtual address
//   tlb_ptag        physical tag for fe_va, valid together with fe_req
//   flush           invalidate every line (single-cycle pulse)
//   fe_stall        fetch must hold fe_req / fe_va / tlb_ptag
//   fe_hit          lookup hit this cycle, array data is valid
//   ic_tag          tag read from the array
//   ic_meta         {valid, dirty} read from the array
//   ic_read_en      array read enable
//   ic_write_en     array write enable
//   ic_va           array access address
//   ic_ptag         tag written into the array
//   ic_wdata        word written into the array
//   ic_valid_data   valid bit written into the array
//   ic_dirty_data   dirty bit written into the array, always 0
//   ic_invalidate   array invalidate-all
//   mem_req         line read request, held until mem_gnt
//   mem_addr        64-byte-aligned line address {ptag, idx, 6'b0}
//   mem_gnt         memory accepted the request
//   mem_rvalid      one 32-bit beat valid, offset 0 first
//   mem_rdata       beat data
// ---------------------------------------------------------------------------
module icache_miss_handler #(
  parameter int LINE_WORDS = 16,
  parameter int TAG_W      = 24,
  parameter int IDX_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fe_req,
  input  logic [31:0]      fe_va,
  input  logic [TAG_W-1:0] tlb_ptag,
  input  logic             flush,
  output logic             fe_stall,
  output logic             fe_hit,
  input  logic [TAG_W-1:0] ic_tag,
  input  logic [1:0]       ic_meta,
  output logic             ic_read_en,
  output logic             ic_write_en,
  output logic [31:0]      ic_va,
  output logic [TAG_W-1:0] ic_ptag,
  output logic [31:0]      ic_wdata,
  output logic             ic_valid_data,
  output logic             ic_dirty_data,
  output logic             ic_invalidate,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam int OFF_W = CNT_W + 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] FILL   = 2'd2;
  localparam logic [1:0] REPLAY = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_abort;
  logic [31:0]      r_line_addr;

  logic w_hit;
  logic w_miss;
  logic w_last;
  logic w_unused;

  // The dirty bit is meaningless for an instruction cache.
  assign w_unused = ic_meta[0];

  // A flush in the lookup cycle kills the hit: the line being read is being
  // invalidated underneath it, so this cycle is treated as a miss.
  assign w_hit  = fe_req & ic_meta[1] & (ic_tag == tlb_ptag) & ~flush;
  assign w_miss = fe_req & ~w_hit;
  assign w_last = (r_beat_cnt == CNT_W'(LINE_WORDS - 1));

  assign ic_invalidate = flush;
  assign ic_dirty_data = 1'b0;

  // Output decode. Outputs depend on the state and on the live inputs. The
  // stall is raised in the very cycle that a miss is seen.
  always_comb begin
    fe_stall      = 1'b0;
    fe_hit        = 1'b0;
    ic_read_en    = 1'b0;
    ic_write_en   = 1'b0;
    ic_va         = 32'd0;
    ic_ptag       = '0;
    ic_wdata      = 32'd0;
    ic_valid_data = 1'b0;
    mem_req       = 1'b0;
    mem_addr      = 32'd0;
    case (r_state)
      IDLE: begin
        ic_read_en = 1'b1;
        ic_va      = fe_va;
        fe_hit     = w_hit;
        fe_stall   = w_miss;
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = r_line_addr;
        fe_stall = 1'b1;
      end
      FILL: begin
        fe_stall = 1'b1;
        ic_va    = {r_line_addr[31:OFF_W], r_beat_cnt, 2'b00};
        if (mem_rvalid) begin
          ic_write_en   = 1'b1;
          ic_wdata      = mem_rdata;
          ic_ptag       = r_line_addr[31:32-TAG_W];
          // The valid bit goes out only with the final beat. A flush that
          // lands on that same beat also suppresses it.
          ic_valid_data = w_last & ~r_abort & ~flush;
        end
      end
      REPLAY: begin
        ic_read_en = 1'b1;
        ic_va      = fe_va;
        fe_stall   = 1'b1;
      end
      default: begin
        ic_read_en = 1'b1;
      end
    endcase
  end

  // Controller state. Once the request has been granted, the fill always
  // drains all beats, even after a flush. A flush only marks the line so
  // that it is not validated. The beat counter restarts only when the
  // request is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_abort     <= 1'b0;
      r_line_addr <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_abort <= 1'b0;
          if (w_miss) begin
            r_line_addr <= {tlb_ptag, fe_va[6+IDX_W-1:6], 6'b0};
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (flush) r_abort <= 1'b1;
          if (mem_gnt) begin
            r_beat_cnt <= '0;
            r_state    <= FILL;
          end
        end
        FILL: begin
          if (flush) r_abort <= 1'b1;
          if (mem_rvalid) begin
            if (w_last) r_state <= REPLAY;
            else        r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        REPLAY: begin
          r_abort <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory must never grant a request and return data in the same cycle.
  a_no_gnt_with_rvalid: assert property (
    @(posedge clk) disable iff (!rst_n) !(mem_gnt && mem_rvalid)
  );

endmodule
